response_collector: RTL and testbench

Gathers responses from multiple ports in parallel after the switch has fanned a request out, and folds them into one result. It is the completion side of the parallel-issue path: the read requester/multicast engine issues to a set of ports, and this block tracks which targeted ports have answered. It sum-reduces their data, ORs their error flags, enforces a timeout, and presents a single result upstream over a valid/ready handshake.

---
 rtl/response_collector.sv | 170 +++++++++++++++++
 tb/tb_response_collector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/response_collector.sv
// rtl/response_collector.sv - gathers parallel per-port responses into one summed result
//
// Tracks which targeted ports have answered after a fan-out request, sums their
// data (wrapping), ORs their error flags, enforces a COLLECT timeout and presents
// one result upstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin collection (IDLE only) / drop current operation
//   target_mask         ports expected to respond, latched on accepted start
//   busy                high whenever not IDLE
//   port_rsp_valid/ready/data/err   per-port response channels
//   out_valid/ready     result handshake
//   out_data            wrapping sum of accepted response data
//   out_err             OR of err over accepted responses
//   out_timeout         result produced by timeout
//   out_missing_mask    expected ports that never responded
module response_collector #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_PORTS-1:0]          target_mask,
  output logic                          busy,
  input  logic [NUM_PORTS-1:0]          port_rsp_valid,
  output logic [NUM_PORTS-1:0]          port_rsp_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_rsp_data,
  input  logic [NUM_PORTS-1:0]          port_rsp_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_err,
  output logic                          out_timeout,
  output logic [NUM_PORTS-1:0]          out_missing_mask
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NUM_PORTS-1:0]  r_expect;
  logic [NUM_PORTS-1:0]  r_got;
  logic [DATA_W-1:0]     r_acc;
  logic                  r_err;
  logic                  r_timeout;
  logic [NUM_PORTS-1:0]  r_missing;
  logic [TW-1:0]         r_timer;

  logic                  w_collect;
  logic                  w_done;
  logic [NUM_PORTS-1:0]  w_fire;
  logic [NUM_PORTS-1:0]  w_got_next;
  logic                  w_complete;
  logic                  w_last_tick;
  logic [DATA_W-1:0]     w_sum;
  logic                  w_err_in;

  assign w_collect = (r_state == S_COLLECT);
  assign w_done    = (r_state == S_DONE);

  // Ready depends only on registered state; a port drops out once it has answered.
  assign port_rsp_ready = w_collect ? (r_expect & ~r_got) : '0;

  // abort suppresses acceptance so nothing from an aborted cycle is ever counted.
  assign w_fire      = port_rsp_valid & port_rsp_ready & {NUM_PORTS{~abort}};
  assign w_got_next  = r_got | w_fire;
  assign w_complete  = (w_got_next == r_expect);
  assign w_last_tick = (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_sum    = r_acc;
    w_err_in = r_err;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_fire[i]) begin
        w_sum    = w_sum + port_rsp_data[i*DATA_W +: DATA_W];
        w_err_in = w_err_in | port_rsp_err[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort)
          w_next = (target_mask == '0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        if (abort)
          w_next = S_IDLE;
        else if (w_complete || w_last_tick)
          w_next = S_DONE;
      end
      S_DONE: begin
        if (abort || out_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expect  <= '0;
      r_got     <= '0;
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_missing <= '0;
      r_timer   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_expect  <= target_mask;
            r_got     <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_missing <= '0;
            r_timer   <= '0;
          end
        end
        S_COLLECT: begin
          if (!abort) begin
            r_got <= w_got_next;
            r_acc <= w_sum;
            r_err <= w_err_in;
            // Completion outranks timeout; the timer stops at TIMEOUT-1 and never wraps.
            if (!w_complete) begin
              if (w_last_tick) begin
                r_timeout <= 1'b1;
                r_missing <= r_expect & ~w_got_next;
              end else begin
                r_timer <= r_timer + TW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result fields are only exposed in DONE so stale partial sums never leak out.
  assign busy             = (r_state != S_IDLE);
  assign out_valid        = w_done;
  assign out_data         = w_done ? r_acc : '0;
  assign out_err          = w_done & r_err;
  assign out_timeout      = w_done & r_timeout;
  assign out_missing_mask = w_done ? r_missing : '0;

endmodule

// File: tb/tb_response_collector.sv
// tb/tb_response_collector.sv - randomized self-checking bench for response_collector
module tb_response_collector;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [NP-1:0]       target_mask;
  logic                busy;
  logic [NP-1:0]       port_rsp_valid;
  logic [NP-1:0]       port_rsp_ready;
  logic [NP*DW-1:0]    port_rsp_data;
  logic [NP-1:0]       port_rsp_err;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic                out_err;
  logic                out_timeout;
  logic [NP-1:0]       out_missing_mask;

  always #5 clk = ~clk;

  response_collector #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .target_mask      (target_mask),
    .busy             (busy),
    .port_rsp_valid   (port_rsp_valid),
    .port_rsp_ready   (port_rsp_ready),
    .port_rsp_data    (port_rsp_data),
    .port_rsp_err     (port_rsp_err),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_err          (out_err),
    .out_timeout      (out_timeout),
    .out_missing_mask (out_missing_mask)
  );

  int checks = 0;
  int errors = 0;

  // Per-operation stimulus: response cycle (relative to start in cycle 0), data, err.
  int          op_t[NP];
  logic [31:0] op_d[NP];
  logic [NP-1:0] op_e;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start          = 1'b0;
    abort          = 1'b0;
    target_mask    = '0;
    port_rsp_valid = '0;
    port_rsp_data  = '0;
    port_rsp_err   = '0;
    out_ready      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, port_rsp_ready, 0);
    check_eq({tag, "_ovalid"}, out_valid, 0);
    check_eq({tag, "_odata"}, out_data, 0);
    check_eq({tag, "_oerr"}, out_err, 0);
    check_eq({tag, "_otmo"}, out_timeout, 0);
    check_eq({tag, "_omiss"}, out_missing_mask, 0);
  endtask

  // One full operation: model predicts completion cycle and result from the
  // per-port response times, then the DUT is driven and checked cycle by cycle.
  task automatic run_op(input logic [NP-1:0] mask, input int hold, input bit poke_start);
    logic [NP-1:0] acc_mask = '0;
    logic [31:0]   exp_sum  = '0;
    logic          exp_err  = 1'b0;
    logic          exp_tmo  = 1'b0;
    logic [NP-1:0] exp_miss = '0;
    logic [NP-1:0] exp_rdy;
    int            last     = 0;
    int            done_c;

    for (int i = 0; i < NP; i++) begin
      if (mask[i] && op_t[i] <= TO) begin
        acc_mask[i] = 1'b1;
        exp_sum     = exp_sum + op_d[i];
        exp_err     = exp_err | op_e[i];
        if (op_t[i] > last) last = op_t[i];
      end
    end
    if (mask == '0) begin
      done_c = 1;
    end else if (acc_mask == mask) begin
      done_c = last + 1;
    end else begin
      done_c   = TO + 1;
      exp_tmo  = 1'b1;
      exp_miss = mask & ~acc_mask;
    end

    @(posedge clk); #1;
    start       = 1'b1;
    target_mask = mask;
    @(negedge clk);
    check_eq("pre_busy", busy, 0);

    for (int c = 1; c <= done_c + hold + 1; c++) begin
      @(posedge clk); #1;
      start       = poke_start && (c >= done_c) && (c <= done_c + hold);
      target_mask = NP'($urandom);
      out_ready   = (c < done_c) ? 1'($urandom) : (c == done_c + hold);
      for (int i = 0; i < NP; i++) begin
        port_rsp_data[i*DW +: DW] = $urandom;
        port_rsp_err[i]           = 1'($urandom);
        if (mask[i]) begin
          port_rsp_valid[i] = (c == op_t[i]);
          if (c == op_t[i]) begin
            port_rsp_data[i*DW +: DW] = op_d[i];
            port_rsp_err[i]           = op_e[i];
          end
        end else begin
          port_rsp_valid[i] = (c >= op_t[i]);
        end
      end
      @(negedge clk);
      if (c < done_c) begin
        for (int i = 0; i < NP; i++) exp_rdy[i] = mask[i] && !(op_t[i] < c);
        check_eq("col_ready", port_rsp_ready, exp_rdy);
        check_eq("col_ovalid", out_valid, 0);
        check_eq("col_busy", busy, 1);
      end else if (c <= done_c + hold) begin
        check_eq("done_ovalid", out_valid, 1);
        check_eq("done_data", out_data, exp_sum);
        check_eq("done_err", out_err, exp_err);
        check_eq("done_tmo", out_timeout, exp_tmo);
        check_eq("done_miss", out_missing_mask, exp_miss);
        check_eq("done_ready", port_rsp_ready, 0);
      end else begin
        check_eq("post_busy", busy, 0);
        check_eq("post_ovalid", out_valid, 0);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic set_port(input int i, input int t, input logic [31:0] d, input bit e);
    op_t[i] = t;
    op_d[i] = d;
    op_e[i] = e;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All four ports in cycle 1, data 1..4.
    for (int i = 0; i < NP; i++) set_port(i, 1, 32'(i + 1), 1'b0);
    run_op(4'b1111, 0, 1'b0);

    // Staggered with wrap; unexpected ports assert valid but must see ready low.
    set_port(0, 3, 32'hFFFF_FFFF, 1'b0);
    set_port(1, 2, 32'h55, 1'b1);
    set_port(2, 7, 32'h2, 1'b0);
    set_port(3, 5, 32'h77, 1'b1);
    run_op(4'b0101, 0, 1'b0);

    // Error with 5 cycles of backpressure; start poked during DONE.
    for (int i = 0; i < NP; i++) set_port(i, NEVER, 32'h0, 1'b0);
    set_port(1, 2, 32'h1234, 1'b1);
    run_op(4'b0010, 5, 1'b1);

    // Timeout: only port 0 answers.
    for (int i = 0; i < NP; i++) set_port(i, NEVER, 32'h0, 1'b0);
    set_port(0, 3, 32'h10, 1'b0);
    run_op(4'b1011, 1, 1'b0);

    // Last response on the timeout cycle: completion wins.
    for (int i = 0; i < NP; i++) set_port(i, NEVER, 32'h0, 1'b0);
    set_port(0, 2, 32'h5, 1'b0);
    set_port(1, TO, 32'h6, 1'b1);
    run_op(4'b0011, 0, 1'b0);

    // Empty mask.
    for (int i = 0; i < NP; i++) set_port(i, 1, $urandom, 1'b1);
    run_op(4'b0000, 2, 1'b1);

    // Abort mid-COLLECT.
    @(posedge clk); #1;
    start = 1'b1; target_mask = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    port_rsp_valid = 4'b0010; port_rsp_data[1*DW +: DW] = 32'h5;
    @(posedge clk); #1;
    port_rsp_valid = '0;
    @(posedge clk); #1;
    abort = 1'b1; port_rsp_valid = 4'b0001; port_rsp_data[0*DW +: DW] = 32'h9;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_all_zero("abort");
    repeat (TO + 2) @(posedge clk);
    @(negedge clk);
    check_eq("abort_later_ovalid", out_valid, 0);
    for (int i = 0; i < NP; i++) set_port(i, NEVER, 32'h0, 1'b0);
    set_port(3, 1, 32'h7, 1'b0);
    run_op(4'b1000, 0, 1'b0);

    // Reset mid-COLLECT: outputs clear immediately.
    @(posedge clk); #1;
    start = 1'b1; target_mask = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    port_rsp_valid = 4'b0001; port_rsp_data[0*DW +: DW] = 32'h9;
    @(posedge clk); #1;
    port_rsp_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_after_busy", busy, 0);

    // Randomized operations.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NP; i++)
        set_port(i, int'($urandom_range(1, TO + 3)), $urandom, 1'($urandom));
      run_op(NP'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
